// File: rtl/ptp_pkg.sv
// Shared definitions for the KA10 paper-tape punch: device code, status layout
// and the punched-byte formatter.
package ptp_pkg;

    localparam logic [6:0] PTP_DEVCODE = 7'b0010000;

    localparam int unsigned PIA_LSB  = 0;
    localparam int unsigned PIA_MSB  = 2;
    localparam int unsigned DONE_BIT = 3;
    localparam int unsigned BUSY_BIT = 4;
    localparam int unsigned BIN_BIT  = 5;

    localparam logic [7:0] BIN_MASK = 8'h80;

    // Packs in CONI order: bin(040) busy(020) done(010) pia(07).
    typedef struct packed {
        logic       bin;
        logic       busy;
        logic       done;
        logic [2:0] pia;
    } status_t;

    // Tape feed punches blank tape; binary mode forces the sprocket/marker hole.
    function automatic logic [7:0] punch_byte(input logic bin, input logic feed,
                                              input logic [7:0] data);
        if (feed)
            return 8'h00;
        else if (bin)
            return BIN_MASK | {2'b00, data[5:0]};
        else
            return data;
    endfunction

endpackage

// File: rtl/ptp_ka10_punch_edge_det.sv
// One-clock rising-edge pulse from a level strobe.
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            prev <= 1'b0;
        else
            prev <= level;
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/ptp_ka10_punch.sv
// KA10 paper-tape punch (device 100): CONO/DATAO/CONI decode, PI request and
// a host-side read port that drains each punched byte.
module ptp_ka10_punch
    import ptp_pkg::*;
#(
    parameter logic [6:0] DEVCODE = PTP_DEVCODE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iobus_iob_poweron,
    input  logic        iobus_iob_reset,
    input  logic        iobus_datao_clear,
    input  logic        iobus_datao_set,
    input  logic        iobus_cono_clear,
    input  logic        iobus_cono_set,
    input  logic        iobus_iob_fm_datai,
    input  logic        iobus_iob_fm_status,
    input  logic [3:9]  iobus_ios,
    input  logic [0:35] iobus_iob_in,
    output logic [1:7]  iobus_pi_req,
    output logic [0:35] iobus_iob_out,
    input  logic        key_tape_feed,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    output logic        fe_data_rq
);

    logic       selected;
    logic       sync_clear;
    logic       cono_clear_p, cono_set_p, datao_clear_p, datao_set_p, read_p;
    logic [5:0] cono_bits;
    logic [7:0] datao_bits;

    status_t    status, status_n;
    logic [7:0] data_buf, data_buf_n;
    logic       feed, feed_n;
    logic       fe_rq, fe_rq_n;

    logic unused;

    assign selected   = (iobus_ios == DEVCODE);
    assign sync_clear = ~iobus_iob_poweron | iobus_iob_reset;
    assign cono_bits  = iobus_iob_in[30:35];
    assign datao_bits = iobus_iob_in[28:35];
    assign unused     = &{1'b0, iobus_iob_fm_datai, iobus_iob_in[0:27]};

    edge_det u_cono_clear  (.clk(clk), .reset(reset), .level(iobus_cono_clear),  .pulse(cono_clear_p));
    edge_det u_cono_set    (.clk(clk), .reset(reset), .level(iobus_cono_set),    .pulse(cono_set_p));
    edge_det u_datao_clear (.clk(clk), .reset(reset), .level(iobus_datao_clear), .pulse(datao_clear_p));
    edge_det u_datao_set   (.clk(clk), .reset(reset), .level(iobus_datao_set),   .pulse(datao_set_p));
    edge_det u_read        (.clk(clk), .reset(reset), .level(s_read),            .pulse(read_p));

    // Later assignments win: completion, then feed, then bus writes, so a
    // DATAO landing with a host read re-arms busy after the completion.
    always_comb begin
        status_n   = status;
        data_buf_n = data_buf;
        feed_n     = feed;
        fe_rq_n    = fe_rq;

        if (status.busy && !fe_rq)
            fe_rq_n = 1'b1;

        if (read_p && fe_rq) begin
            fe_rq_n       = 1'b0;
            status_n.busy = 1'b0;
            if (!feed)
                status_n.done = 1'b1;
            feed_n = 1'b0;
        end

        if (key_tape_feed && !status.busy) begin
            feed_n        = 1'b1;
            status_n.busy = 1'b1;
        end

        if (selected) begin
            if (cono_clear_p)
                status_n = '0;
            if (cono_set_p)
                status_n = status_t'(status_n | cono_bits);
            if (datao_clear_p)
                data_buf_n = '0;
            if (datao_set_p) begin
                data_buf_n    = data_buf_n | datao_bits;
                status_n.busy = 1'b1;
                status_n.done = 1'b0;
                feed_n        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status   <= '0;
            data_buf <= '0;
            feed     <= 1'b0;
            fe_rq    <= 1'b0;
        end else if (sync_clear) begin
            status   <= '0;
            data_buf <= '0;
            feed     <= 1'b0;
            fe_rq    <= 1'b0;
        end else begin
            status   <= status_n;
            data_buf <= data_buf_n;
            feed     <= feed_n;
            fe_rq    <= fe_rq_n;
        end
    end

    always_comb begin
        iobus_pi_req = '0;
        for (int unsigned i = 1; i <= 7; i++)
            iobus_pi_req[i] = status.done && (status.pia == i[2:0]);
    end

    assign iobus_iob_out = (selected && iobus_iob_fm_status) ? {30'b0, status} : '0;
    assign s_readdata    = {24'b0, punch_byte(status.bin, feed, data_buf)};
    assign fe_data_rq    = fe_rq;

endmodule

// File: tb/tb_ptp_ka10_punch.sv
// Directed bench for the KA10 paper-tape punch with an expectation queue.
module tb_ptp_ka10_punch;

    localparam logic [6:0] DEV = 7'b0010000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        poweron = 1'b1;
    logic        iob_reset = 1'b0;
    logic        datao_clear = 1'b0;
    logic        datao_set = 1'b0;
    logic        cono_clear = 1'b0;
    logic        cono_set = 1'b0;
    logic        fm_datai = 1'b0;
    logic        fm_status = 1'b0;
    logic [3:9]  ios = DEV;
    logic [0:35] iob_in = '0;
    logic [1:7]  pi_req;
    logic [0:35] iob_out;
    logic        key_feed = 1'b0;
    logic        s_read = 1'b0;
    logic [31:0] s_readdata;
    logic        fe_data_rq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [35:0] value;
    } exp_t;
    exp_t sb[$];

    ptp_ka10_punch #(.DEVCODE(DEV)) dut (
        .clk(clk),
        .reset(reset),
        .iobus_iob_poweron(poweron),
        .iobus_iob_reset(iob_reset),
        .iobus_datao_clear(datao_clear),
        .iobus_datao_set(datao_set),
        .iobus_cono_clear(cono_clear),
        .iobus_cono_set(cono_set),
        .iobus_iob_fm_datai(fm_datai),
        .iobus_iob_fm_status(fm_status),
        .iobus_ios(ios),
        .iobus_iob_in(iob_in),
        .iobus_pi_req(pi_req),
        .iobus_iob_out(iob_out),
        .key_tape_feed(key_feed),
        .s_read(s_read),
        .s_readdata(s_readdata),
        .fe_data_rq(fe_data_rq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic expect_val(input string tag, input logic [35:0] v);
        exp_t e;
        e.tag = tag;
        e.value = v;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [35:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.value) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 cono_clear, 1 cono_set, 2 datao_clear, 3 datao_set
    task automatic strobe(input int which, input logic [35:0] data, input int hold);
        iob_in = data;
        case (which)
            0: cono_clear = 1'b1;
            1: cono_set = 1'b1;
            2: datao_clear = 1'b1;
            default: datao_set = 1'b1;
        endcase
        step(hold);
        cono_clear = 1'b0;
        cono_set = 1'b0;
        datao_clear = 1'b0;
        datao_set = 1'b0;
        iob_in = '0;
    endtask

    task automatic check_coni(input string tag, input logic [35:0] v);
        expect_val(tag, v);
        fm_status = 1'b1;
        #1;
        observe(iob_out);
        fm_status = 1'b0;
    endtask

    task automatic check_pi(input string tag, input logic [6:0] v);
        expect_val(tag, {29'b0, v});
        observe({29'b0, pi_req});
    endtask

    task automatic check_byte(input string tag, input logic [7:0] v);
        expect_val(tag, {28'b0, v});
        observe({4'b0, s_readdata});
    endtask

    task automatic check_rq(input string tag, input logic v);
        expect_val(tag, {35'b0, v});
        observe({35'b0, fe_data_rq});
    endtask

    task automatic wait_rq(input string tag);
        int n = 0;
        while (fe_data_rq !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check_rq(tag, 1'b1);
    endtask

    task automatic host_read();
        s_read = 1'b1;
        step(1);
        s_read = 1'b0;
    endtask

    initial begin
        // Reset with the feed key already held
        key_feed = 1'b1;
        step(2);
        check_rq("rst_rq", 1'b0);
        check_pi("rst_pi", 7'b0);
        check_byte("rst_byte", 8'h00);
        check_coni("rst_coni", 36'o0);
        reset = 1'b1;

        wait_rq("feed_rq1");
        check_byte("feed_byte", 8'h00);
        host_read();
        check_coni("feed_done_clear", 36'o0);
        wait_rq("feed_rq2");
        key_feed = 1'b0;
        host_read();
        step(2);
        check_rq("feed_drained", 1'b0);
        check_coni("feed_idle", 36'o0);

        // CONO 060: binary mode and busy
        strobe(0, 36'o0, 1);
        strobe(1, 36'o60, 1);
        check_coni("coni_060", 36'o60);
        wait_rq("rq_060");
        check_byte("byte_bin_empty", 8'h80);
        host_read();
        check_coni("coni_050", 36'o50);
        check_pi("pi_pia0", 7'b0);

        // Alpha mode punch of 0177 on PI channel 1
        strobe(0, 36'o0, 1);
        strobe(1, 36'o1, 1);
        strobe(3, 36'o177, 1);
        wait_rq("rq_alpha");
        check_byte("byte_alpha", 8'o177);
        check_pi("pi_busy", 7'b0);
        host_read();
        check_pi("pi_alpha", 7'b1000000);
        check_coni("coni_alpha", 36'o11);

        // Binary mode punch of 0377
        strobe(0, 36'o0, 1);
        strobe(1, 36'o41, 1);
        strobe(2, 36'o0, 1);
        strobe(3, 36'o377, 1);
        wait_rq("rq_bin");
        check_byte("byte_bin", 8'hBF);
        host_read();
        check_coni("coni_bin", 36'o51);
        check_pi("pi_bin", 7'b1000000);

        // Not selected: CONO ignored, CONI silent
        ios = 7'b0;
        strobe(1, 36'o67, 1);
        check_coni("unsel_coni", 36'o0);
        ios = DEV;
        step(2);
        check_coni("unsel_status", 36'o51);
        check_rq("unsel_rq", 1'b0);
        expect_val("datai_zero", 36'o0);
        fm_datai = 1'b1;
        #1;
        observe(iob_out);
        fm_datai = 1'b0;

        // DATAO held four clocks with a completion in the middle acts once
        iob_in = '0;
        datao_set = 1'b1;
        step(2);
        s_read = 1'b1;
        step(1);
        s_read = 1'b0;
        step(1);
        datao_set = 1'b0;
        step(2);
        check_coni("held_once", 36'o51);
        check_rq("held_rq", 1'b0);

        // IO reset mid-punch
        strobe(3, 36'o0, 1);
        wait_rq("rq_mid");
        strobe(1, 36'o10, 1);
        check_pi("pi_mid", 7'b1000000);
        iob_reset = 1'b1;
        step(1);
        iob_reset = 1'b0;
        check_rq("iorst_rq", 1'b0);
        check_coni("iorst_coni", 36'o0);
        check_pi("iorst_pi", 7'b0);
        check_byte("iorst_byte", 8'h00);

        // Stray host read is ignored
        host_read();
        step(1);
        check_coni("stray_read", 36'o0);

        // Power-off clears too
        strobe(1, 36'o12, 1);
        check_pi("pi_ch2", 7'b0100000);
        poweron = 1'b0;
        step(1);
        poweron = 1'b1;
        check_pi("poweroff_pi", 7'b0);
        check_coni("poweroff_coni", 36'o0);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
